// File: rtl/pdm_mic_receiver.sv
// pdm_mic_receiver: clocks a PDM microphone, decimates its bitstream to PCM words,
// and turns loud onsets into single-cycle flap pulses via a hysteretic detector.
module pdm_mic_receiver #(
  parameter int MIC_CLK_DIV  = 40,
  parameter int DECIM        = 128,
  parameter int THRESH_HI    = 24,
  parameter int THRESH_LO    = 12,
  parameter int HOLD_WINDOWS = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     micData,
  output logic                     micClk,
  output logic                     chSel,
  output logic [$clog2(DECIM):0]   pcm_sample,
  output logic                     pcm_valid,
  output logic [$clog2(DECIM)-1:0] level,
  output logic                     flap,
  output logic                     loud
);
  localparam int LW = $clog2(DECIM);
  localparam int PW = LW + 1;
  localparam int HW = $clog2(MIC_CLK_DIV / 2);
  localparam logic [HW-1:0] HC_TERM = HW'(MIC_CLK_DIV / 2 - 1);
  localparam logic [PW-1:0] MID = PW'(DECIM / 2);
  localparam logic [LW-1:0] TH_HI = LW'(THRESH_HI);
  localparam logic [LW-1:0] TH_LO = LW'(THRESH_LO);
  localparam logic [7:0] HOLD_LD = 8'(HOLD_WINDOWS - 1);

  typedef enum logic [1:0] {QUIET, LOUD, HOLDOFF} state_t;

  state_t state, state_n;
  logic [HW-1:0] hc;
  logic s1, s2;
  logic [LW-1:0] bit_cnt;
  logic [PW-1:0] acc, pcm_next, dev;
  logic [7:0] hold, hold_n;
  logic strobe, last;

  assign chSel    = 1'b0;
  assign strobe   = hc == HC_TERM && micClk;
  assign last     = strobe && bit_cnt == '1;
  assign pcm_next = acc + PW'(s2);
  assign dev      = pcm_next >= MID ? pcm_next - MID : MID - pcm_next;

  // The window that enters HOLDOFF counts as the first of the quiet windows.
  always_comb begin
    state_n = state;
    hold_n  = hold;
    if (pcm_valid)
      case (state)
        QUIET: state_n = level >= TH_HI ? LOUD : QUIET;
        LOUD: if (level < TH_LO) begin
          state_n = HOLD_WINDOWS == 1 ? QUIET : HOLDOFF;
          hold_n  = HOLD_LD;
        end
        HOLDOFF: if (level >= TH_LO) state_n = LOUD;
        else begin
          hold_n  = hold - 8'd1;
          state_n = hold == 8'd1 ? QUIET : HOLDOFF;
        end
        default: state_n = QUIET;
      endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= micData;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hc         <= '0;
      micClk     <= 1'b0;
      acc        <= '0;
      bit_cnt    <= '0;
      hold       <= '0;
      state      <= QUIET;
      pcm_sample <= '0;
      level      <= '0;
      pcm_valid  <= 1'b0;
      flap       <= 1'b0;
      loud       <= 1'b0;
    end else if (!enable) begin
      hc        <= '0;
      micClk    <= 1'b0;
      acc       <= '0;
      bit_cnt   <= '0;
      hold      <= '0;
      state     <= QUIET;
      pcm_valid <= 1'b0;
      flap      <= 1'b0;
      loud      <= 1'b0;
    end else begin
      hc        <= hc == HC_TERM ? '0 : hc + 1'b1;
      micClk    <= hc == HC_TERM ? ~micClk : micClk;
      pcm_valid <= last;
      if (strobe) begin
        acc     <= last ? '0 : pcm_next;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (last) begin
        pcm_sample <= pcm_next;
        level      <= LW'(dev);
      end
      hold  <= hold_n;
      state <= state_n;
      flap  <= pcm_valid && state == QUIET && state_n == LOUD;
      loud  <= state_n != QUIET;
    end
  end
endmodule

// File: tb/tb_pdm_mic_receiver.sv
// tb_pdm_mic_receiver: directed windows with hand-computed PCM, level and detector results.
module tb_pdm_mic_receiver;
  logic clk = 0, reset_n = 0, enable = 0, micData = 0;
  logic micClk, chSel, pcm_valid, flap, loud;
  logic [7:0] pcm_sample;
  logic [6:0] level;
  int checks = 0, errors = 0;
  int flap_cnt = 0, pv_cnt = 0, wide_cnt = 0;
  logic prev_flap = 0, post_loud = 0, post_flap = 0;

  always #5 clk = ~clk;

  pdm_mic_receiver dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .micData(micData),
    .micClk(micClk), .chSel(chSel), .pcm_sample(pcm_sample), .pcm_valid(pcm_valid),
    .level(level), .flap(flap), .loud(loud)
  );

  always @(posedge clk) begin
    #1;
    if (pcm_valid) pv_cnt++;
    if (flap) flap_cnt++;
    if (flap && prev_flap) wide_cnt++;
    prev_flap = flap;
  end

  task automatic start();
    @(negedge clk);
    reset_n = 0; enable = 0; micData = 0;
    @(negedge clk);
    reset_n = 1; enable = 1;
  endtask

  // Sample i is driven at enabled negedge 40*i; its strobe lands 40 cycles later.
  task automatic run_window(input int ones, input bit alt, input int first);
    for (int i = first; i < 128; i++) begin
      micData = alt ? ~i[0] : (i < ones);
      @(negedge clk);
      if (i == first) begin post_loud = loud; post_flap = flap; end
      repeat (39) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 0; enable = 0;
    repeat (3) @(negedge clk);
    checks++; if (micClk !== 1'b0) begin errors++; $display("FAIL reset_micClk: got %b want 0", micClk); end
    checks++; if (pcm_valid !== 1'b0) begin errors++; $display("FAIL reset_pcm_valid: got %b want 0", pcm_valid); end
    checks++; if (pcm_sample !== 8'd0) begin errors++; $display("FAIL reset_pcm_sample: got %0d want 0", pcm_sample); end
    checks++; if (level !== 7'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (flap !== 1'b0) begin errors++; $display("FAIL reset_flap: got %b want 0", flap); end
    checks++; if (loud !== 1'b0) begin errors++; $display("FAIL reset_loud: got %b want 0", loud); end
    checks++; if (chSel !== 1'b0) begin errors++; $display("FAIL reset_chSel: got %b want 0", chSel); end
  endtask

  task automatic test_all_ones_and_holdoff();
    int at[8] = '{19, 20, 39, 40, 59, 60, 79, 80};
    logic exp_clk[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    int t = 0;
    int pv0, f0;
    start();
    micData = 1; pv0 = pv_cnt; f0 = flap_cnt;
    for (int k = 0; k < 8; k++) begin
      while (t < at[k]) begin @(negedge clk); t++; end
      checks++; if (micClk !== exp_clk[k]) begin errors++; $display("FAIL micClk_phase@%0d: got %b want %b", at[k], micClk, exp_clk[k]); end
    end
    run_window(128, 0, 2);
    checks++; if (pcm_valid !== 1'b1) begin errors++; $display("FAIL first_valid@5121: got %b want 1", pcm_valid); end
    checks++; if (pv_cnt - pv0 !== 1) begin errors++; $display("FAIL first_valid_count: got %0d want 1", pv_cnt - pv0); end
    checks++; if (pcm_sample !== 8'd128) begin errors++; $display("FAIL ones_pcm: got %0d want 128", pcm_sample); end
    checks++; if (level !== 7'd64) begin errors++; $display("FAIL ones_level: got %0d want 64", level); end
    checks++; if (flap !== 1'b0) begin errors++; $display("FAIL flap_early: got %b want 0", flap); end
    checks++; if (chSel !== 1'b0) begin errors++; $display("FAIL chSel: got %b want 0", chSel); end
    run_window(0, 1, 0);
    checks++; if (post_flap !== 1'b1) begin errors++; $display("FAIL flap@5122: got %b want 1", post_flap); end
    checks++; if (post_loud !== 1'b1) begin errors++; $display("FAIL loud_after_flap: got %b want 1", post_loud); end
    checks++; if (pcm_sample !== 8'd64 || level !== 7'd0) begin errors++; $display("FAIL mix_pcm: got %0d/%0d want 64/0", pcm_sample, level); end
    run_window(0, 1, 0);
    checks++; if (post_loud !== 1'b1) begin errors++; $display("FAIL holdoff_q1_loud: got %b want 1", post_loud); end
    run_window(128, 0, 0);
    checks++; if (post_loud !== 1'b1) begin errors++; $display("FAIL holdoff_q2_loud: got %b want 1", post_loud); end
    checks++; if (pcm_sample !== 8'd128) begin errors++; $display("FAIL reloud_pcm: got %0d want 128", pcm_sample); end
    for (int r = 1; r <= 4; r++) begin
      run_window(0, 1, 0);
      checks++; if (post_loud !== 1'b1) begin errors++; $display("FAIL loud_before_r%0d: got %b want 1", r, post_loud); end
      checks++; if (post_flap !== 1'b0) begin errors++; $display("FAIL no_reflap_r%0d: got %b want 0", r, post_flap); end
    end
    checks++; if (loud !== 1'b1) begin errors++; $display("FAIL loud_at_4th_valid: got %b want 1", loud); end
    @(negedge clk);
    checks++; if (loud !== 1'b0) begin errors++; $display("FAIL loud_drop_after_4th: got %b want 0", loud); end
    checks++; if (flap_cnt - f0 !== 1) begin errors++; $display("FAIL flap_count_holdoff: got %0d want 1", flap_cnt - f0); end
  endtask

  task automatic test_threshold();
    int f0;
    start();
    f0 = flap_cnt;
    for (int w = 0; w < 2; w++) begin
      run_window(0, 1, 0);
      checks++; if (pcm_valid !== 1'b1 || pcm_sample !== 8'd64 || level !== 7'd0) begin errors++; $display("FAIL alt_win%0d: got v%b %0d/%0d want v1 64/0", w, pcm_valid, pcm_sample, level); end
    end
    run_window(87, 0, 0);
    checks++; if (post_flap !== 1'b0 || post_loud !== 1'b0) begin errors++; $display("FAIL alt_detect: got flap %b loud %b want 0 0", post_flap, post_loud); end
    checks++; if (pcm_sample !== 8'd87 || level !== 7'd23) begin errors++; $display("FAIL pcm87: got %0d/%0d want 87/23", pcm_sample, level); end
    run_window(88, 0, 0);
    checks++; if (post_flap !== 1'b0 || post_loud !== 1'b0) begin errors++; $display("FAIL level23_detect: got flap %b loud %b want 0 0", post_flap, post_loud); end
    checks++; if (pcm_sample !== 8'd88 || level !== 7'd24) begin errors++; $display("FAIL pcm88: got %0d/%0d want 88/24", pcm_sample, level); end
    @(negedge clk);
    checks++; if (flap !== 1'b1 || loud !== 1'b1) begin errors++; $display("FAIL level24_detect: got flap %b loud %b want 1 1", flap, loud); end
    checks++; if (flap_cnt - f0 !== 1) begin errors++; $display("FAIL flap_count_thresh: got %0d want 1", flap_cnt - f0); end
  endtask

  task automatic test_reset_and_enable();
    int pv0;
    micData = 1;
    repeat (2989) @(negedge clk);
    reset_n = 0;
    #1;
    checks++; if (micClk !== 1'b0 || pcm_valid !== 1'b0 || flap !== 1'b0 || loud !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: got clk%b v%b f%b l%b want 0000", micClk, pcm_valid, flap, loud); end
    checks++; if (pcm_sample !== 8'd0 || level !== 7'd0) begin errors++; $display("FAIL midreset_data: got %0d/%0d want 0/0", pcm_sample, level); end
    @(negedge clk);
    reset_n = 1; enable = 1; pv0 = pv_cnt;
    run_window(100, 0, 0);
    checks++; if (pcm_valid !== 1'b1 || pv_cnt - pv0 !== 1) begin errors++; $display("FAIL post_reset_valid: got v%b count %0d want v1 count 1", pcm_valid, pv_cnt - pv0); end
    checks++; if (pcm_sample !== 8'd100 || level !== 7'd36) begin errors++; $display("FAIL post_reset_pcm: got %0d/%0d want 100/36", pcm_sample, level); end
    micData = 1;
    @(negedge clk);
    checks++; if (flap !== 1'b1 || loud !== 1'b1) begin errors++; $display("FAIL pcm100_detect: got flap %b loud %b want 1 1", flap, loud); end
    repeat (999) @(negedge clk);
    enable = 0;
    repeat (10) @(negedge clk);
    checks++; if (micClk !== 1'b0 || pcm_valid !== 1'b0 || flap !== 1'b0 || loud !== 1'b0) begin errors++; $display("FAIL disable_ctrl: got clk%b v%b f%b l%b want 0000", micClk, pcm_valid, flap, loud); end
    checks++; if (pcm_sample !== 8'd100 || level !== 7'd36) begin errors++; $display("FAIL disable_hold: got %0d/%0d want 100/36", pcm_sample, level); end
    enable = 1; pv0 = pv_cnt;
    run_window(0, 1, 0);
    checks++; if (pcm_valid !== 1'b1 || pv_cnt - pv0 !== 1) begin errors++; $display("FAIL reenable_valid: got v%b count %0d want v1 count 1", pcm_valid, pv_cnt - pv0); end
    checks++; if (pcm_sample !== 8'd64 || level !== 7'd0) begin errors++; $display("FAIL reenable_pcm: got %0d/%0d want 64/0", pcm_sample, level); end
    @(negedge clk);
    checks++; if (flap !== 1'b0 || loud !== 1'b0) begin errors++; $display("FAIL reenable_detect: got flap %b loud %b want 0 0", flap, loud); end
    checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL flap_width: got %0d wide pulses want 0", wide_cnt); end
  endtask

  initial begin
    test_reset();
    test_all_ones_and_holdoff();
    test_threshold();
    test_reset_and_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
